// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths and arbiter owner type
package mem_port_arbiter_pkg;
  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} arb_owner_e;
endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// sat_counter: up counter with synchronous clear that holds at MAX
module sat_counter #(
  parameter int W = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (inc && cnt != MAX) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and memory stages
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_WIDTH,
  parameter int DATA_W = DATA,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              misalign_err,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       mem_stall_cnt
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic [ADDR_W-1:0] sel_addr;
  arb_owner_e owner;
  always_comb begin
    if_gnt     = !rst && if_req && (!mem_req || starve_cnt == SW'(STARVE_LIMIT));
    mem_gnt    = !rst && mem_req && !if_gnt;
    if_stall   = !rst && if_req && !if_gnt;
    mem_stall  = !rst && mem_req && !mem_gnt;
    sel_addr   = if_gnt ? if_addr : mem_addr;
    ram_en     = if_gnt || mem_gnt;
    ram_we     = mem_gnt && mem_we;
    ram_addr   = {sel_addr[ADDR_W-1:2], 2'b00};
    ram_wdata  = mem_gnt ? mem_wdata : '0;
    if_rvalid  = !rst && owner == OWN_IF;
    mem_rvalid = !rst && owner == OWN_MEM;
    if_rdata   = if_rvalid ? ram_rdata : '0;
    mem_rdata  = mem_rvalid ? ram_rdata : '0;
  end
  // Owner is pipelined one cycle so alternating back-to-back reads route correctly.
  always_ff @(posedge clk) begin
    owner <= rst ? OWN_NONE : if_gnt ? OWN_IF : (mem_gnt && !mem_we) ? OWN_MEM : OWN_NONE;
    misalign_err <= rst ? 1'b0 : misalign_err | (if_gnt && |if_addr[1:0]) | (mem_gnt && |mem_addr[1:0]);
  end
  sat_counter #(.W(SW), .MAX(SW'(STARVE_LIMIT))) u_starve (
    .clk(clk), .rst(rst), .inc(if_stall), .clr(if_gnt || !if_req), .cnt(starve_cnt));
  sat_counter #(.W(32)) u_if_stall (
    .clk(clk), .rst(rst), .inc(if_stall), .clr(1'b0), .cnt(if_stall_cnt));
  sat_counter #(.W(32)) u_mem_stall (
    .clk(clk), .rst(rst), .inc(mem_stall), .clr(1'b0), .cnt(mem_stall_cnt));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant, routing, starvation and counters
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, mem_req = 0, mem_we = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, ram_rdata = 0;
  logic if_gnt, if_rvalid, if_stall, mem_gnt, mem_rvalid, mem_stall;
  logic ram_en, ram_we, misalign_err;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, if_stall_cnt, mem_stall_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .misalign_err(misalign_err),
    .if_stall_cnt(if_stall_cnt), .mem_stall_cnt(mem_stall_cnt));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    if_req = 0; mem_req = 0; mem_we = 0;
    tick();
  endtask
  task automatic test_reset;
    rst = 1; if_req = 1; mem_req = 1;
    tick(); tick();
    #1;
    checks++; if ({if_gnt, mem_gnt, ram_en} !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", {if_gnt, mem_gnt, ram_en}); end
    checks++; if ({if_stall, mem_stall} !== 2'b00) begin errors++; $display("FAIL reset_stall got %b exp 00", {if_stall, mem_stall}); end
    checks++; if ({if_stall_cnt, mem_stall_cnt} !== 64'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", {if_stall_cnt, mem_stall_cnt}); end
    checks++; if ({misalign_err, if_rvalid, mem_rvalid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {misalign_err, if_rvalid, mem_rvalid}); end
    if_req = 0; mem_req = 0;
    tick();
    rst = 0;
  endtask
  task automatic test_if_read;
    if_req = 1; if_addr = 32'h10;
    #1;
    checks++; if ({if_gnt, mem_gnt, ram_en, ram_we} !== 4'b1010) begin errors++; $display("FAIL if_read_gnt got %b exp 1010", {if_gnt, mem_gnt, ram_en, ram_we}); end
    checks++; if (ram_addr !== 32'h10) begin errors++; $display("FAIL if_read_addr got %h exp 10", ram_addr); end
    tick();
    if_req = 0; ram_rdata = 32'h8C010004;
    #1;
    checks++; if ({if_rvalid, mem_rvalid} !== 2'b10) begin errors++; $display("FAIL if_read_rvalid got %b exp 10", {if_rvalid, mem_rvalid}); end
    checks++; if (if_rdata !== 32'h8C010004) begin errors++; $display("FAIL if_read_rdata got %h exp 8c010004", if_rdata); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL if_read_mem_rdata got %h exp 0", mem_rdata); end
    tick();
  endtask
  task automatic test_starve;
    if_req = 1; mem_req = 1; mem_we = 0; if_addr = 32'h100; mem_addr = 32'h200;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({if_gnt, mem_gnt} !== ((c % 5 == 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL starve_seq cycle %0d got %b exp %b", c, {if_gnt, mem_gnt}, (c % 5 == 4) ? 2'b10 : 2'b01);
      end
      tick();
      if (c == 4) begin
        checks++; if (if_stall_cnt !== 32'd4) begin errors++; $display("FAIL starve_cnt5 got %0d exp 4", if_stall_cnt); end
      end
    end
    checks++; if (if_stall_cnt !== 32'd8) begin errors++; $display("FAIL starve_if_cnt got %0d exp 8", if_stall_cnt); end
    checks++; if (mem_stall_cnt !== 32'd2) begin errors++; $display("FAIL starve_mem_cnt got %0d exp 2", mem_stall_cnt); end
    idle();
  endtask
  task automatic test_write_conflict;
    mem_req = 1; mem_we = 1; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h40;
    #1;
    checks++; if ({mem_gnt, if_gnt, ram_we, if_stall} !== 4'b1011) begin errors++; $display("FAIL wr_gnt got %b exp 1011", {mem_gnt, if_gnt, ram_we, if_stall}); end
    checks++; if (ram_addr !== 32'h20) begin errors++; $display("FAIL wr_addr got %h exp 20", ram_addr); end
    checks++; if (ram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", ram_wdata); end
    tick();
    if_req = 0; mem_req = 0; mem_we = 0;
    #1;
    checks++; if ({if_rvalid, mem_rvalid} !== 2'b00) begin errors++; $display("FAIL wr_rvalid got %b exp 00", {if_rvalid, mem_rvalid}); end
    tick();
  endtask
  task automatic test_misalign;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_pre got %b exp 0", misalign_err); end
    mem_req = 1; mem_we = 0; mem_addr = 32'h23;
    #1;
    checks++; if (ram_addr !== 32'h20 || mem_gnt !== 1'b1) begin errors++; $display("FAIL misalign_addr got %h/%b exp 20/1", ram_addr, mem_gnt); end
    tick();
    mem_req = 0; ram_rdata = 32'h12345678;
    #1;
    checks++; if (mem_rdata !== 32'h12345678 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL misalign_rdata got %h/%b exp 12345678/1", mem_rdata, mem_rvalid); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_set got %b exp 1", misalign_err); end
    tick(); tick(); tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_hold got %b exp 1", misalign_err); end
  endtask
  task automatic test_reset_kills_rvalid;
    mem_req = 1; mem_we = 0; mem_addr = 32'h30;
    #1;
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL rstkill_gnt got %b exp 1", mem_gnt); end
    tick();
    mem_req = 0; rst = 1; ram_rdata = 32'hCAFEF00D;
    #1;
    checks++; if ({mem_rvalid, mem_rdata} !== 33'd0) begin errors++; $display("FAIL rstkill_rvalid got %b/%h exp 0/0", mem_rvalid, mem_rdata); end
    tick();
    checks++; if ({if_stall_cnt, mem_stall_cnt} !== 64'd0) begin errors++; $display("FAIL rstkill_cnt got %h exp 0", {if_stall_cnt, mem_stall_cnt}); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rstkill_misalign got %b exp 0", misalign_err); end
    rst = 0;
    tick();
  endtask
  task automatic test_saturate;
    force dut.u_mem_stall.cnt = 32'hFFFF_FFFD;
    #1;
    release dut.u_mem_stall.cnt;
    #1;
    checks++; if (mem_stall_cnt !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sat_preload got %h exp fffffffd", mem_stall_cnt); end
    if_req = 1; mem_req = 1; mem_we = 0; if_addr = 32'h0; mem_addr = 32'h4;
    for (int c = 0; c < 5; c++) tick();
    checks++; if (mem_stall_cnt !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_step got %h exp fffffffe", mem_stall_cnt); end
    for (int c = 0; c < 10; c++) tick();
    checks++; if (mem_stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h exp ffffffff", mem_stall_cnt); end
    idle();
  endtask
  initial begin
    test_reset();
    test_if_read();
    test_starve();
    test_write_conflict();
    test_misalign();
    test_reset_kills_rvalid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
